// File: rtl/payload_gap_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : payload_gap_engine_if
// Brief    : Byte-stream bus between the class decoder and one gap engine.
// Revision : 1.0 - initial release
// ============================================================================
interface payload_gap_engine_if #(
  parameter int N_CLASS = 64,
  parameter int OFF_W   = 16
);
  logic               en;
  logic [N_CLASS-1:0] in_class;
  logic               out;
  logic [OFF_W-1:0]   match_offset;

  modport master (
    output en,
    output in_class,
    input  out,
    input  match_offset
  );

  modport slave (
    input  en,
    input  in_class,
    output out,
    output match_offset
  );
endinterface
`default_nettype wire

// File: rtl/payload_gap_engine.sv
`default_nettype none
// ============================================================================
// Module   : payload_gap_engine
// Brief    : One-hot NFA matcher for a class chain with one optional gap.
//            Optional macro PAYLOAD_ENGINE_OFFSET_EN builds the offset counter.
// Revision : 1.0 - initial release
// ============================================================================
module payload_gap_engine #(
  parameter int                           N_STAGES    = 8,
  parameter int                           N_CLASS     = 64,
  parameter int                           CLS_W       = 6,
  parameter logic [N_STAGES*CLS_W-1:0]    STAGE_CLASS = '0,
  parameter int                           GAP_POS     = 0,
  parameter int                           GAP_CLASS   = 0,
  parameter int                           GAP_MIN     = 1,
  parameter int                           GAP_MAX     = 0,
  parameter int                           OFF_W       = 16
) (
  input  logic                  clk,
  input  logic                  sod,
  payload_gap_engine_if.slave   bus
);

  localparam int  C_GAP_LEN = (GAP_MAX != 0) ? GAP_MAX : ((GAP_MIN > 1) ? GAP_MIN : 1);
  localparam bit  C_GAP_UNB = (GAP_MAX == 0);

  // s_q[k] holds stage k+1; the final stage feeds out directly and needs no bit.
  logic [N_STAGES-2:0] s_q, s_d;
  logic [N_STAGES-1:0] w_hit;
  logic [N_STAGES-1:0] w_src;
  logic                w_final;
  logic                out_q, out_d;

  genvar k;
  generate
    for (k = 0; k < N_STAGES; k++) begin : g_hit
      assign w_hit[k] = bus.in_class[STAGE_CLASS[k*CLS_W +: CLS_W]];
    end
  endgenerate

  assign w_src[0] = 1'b1;

  generate
    if (GAP_POS != 0) begin : g_gap
      logic [C_GAP_LEN:1] g_q, g_d;
      logic               w_gap_hit;
      logic               w_gap_term;

      assign w_gap_hit = bus.in_class[GAP_CLASS];

      always_comb begin
        g_d = g_q;
        if (bus.en) begin
          g_d[1] = w_gap_hit & s_q[GAP_POS-1];
          for (int j = 2; j <= C_GAP_LEN; j++) begin
            g_d[j] = w_gap_hit & g_q[j-1];
          end
          if (C_GAP_UNB) begin
            g_d[C_GAP_LEN] = g_d[C_GAP_LEN] | (w_gap_hit & g_q[C_GAP_LEN]);
          end
        end
      end

      always_comb begin
        w_gap_term = (GAP_MIN == 0) ? s_q[GAP_POS-1] : 1'b0;
        for (int j = 1; j <= C_GAP_LEN; j++) begin
          if (j >= GAP_MIN) begin
            w_gap_term = w_gap_term | g_q[j];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (sod) begin
          g_q <= '0;
        end else begin
          g_q <= g_d;
        end
      end

      for (k = 1; k < N_STAGES; k++) begin : g_src
        if (k == GAP_POS) begin : g_after_gap
          assign w_src[k] = w_gap_term;
        end else begin : g_chain
          assign w_src[k] = s_q[k-1];
        end
      end
    end else begin : g_plain
      for (k = 1; k < N_STAGES; k++) begin : g_src
        assign w_src[k] = s_q[k-1];
      end
    end
  endgenerate

  assign w_final = w_hit[N_STAGES-1] & w_src[N_STAGES-1];

  always_comb begin
    s_d   = s_q;
    out_d = out_q;
    if (bus.en) begin
      for (int i = 0; i < N_STAGES-1; i++) begin
        s_d[i] = w_hit[i] & w_src[i];
      end
      out_d = out_q | w_final;
    end
  end

  always_ff @(posedge clk) begin
    if (sod) begin
      s_q   <= '0;
      out_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

`ifdef PAYLOAD_ENGINE_OFFSET_EN
  logic [OFF_W-1:0] bcnt_q, bcnt_d;
  logic [OFF_W-1:0] match_offset_q, match_offset_d;

  always_comb begin
    bcnt_d         = bcnt_q;
    match_offset_d = match_offset_q;
    if (bus.en) begin
      if (bcnt_q != {OFF_W{1'b1}}) begin
        bcnt_d = bcnt_q + 1'b1;
      end
      // Only the first completion of the packet is recorded.
      if (w_final && !out_q) begin
        match_offset_d = bcnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sod) begin
      bcnt_q         <= '0;
      match_offset_q <= '0;
    end else begin
      bcnt_q         <= bcnt_d;
      match_offset_q <= match_offset_d;
    end
  end

  assign bus.match_offset = match_offset_q;
`else
  assign bus.match_offset = '0;
`endif

endmodule
`default_nettype wire
